// File: rtl/modulo_controlador_reservatorio_rolhas_if.sv
// Handshake and status bundle between the cork reservoir controller and the line.
`timescale 1ns/1ps
interface modulo_controlador_reservatorio_rolhas_if #(
  parameter int LARGURA = 7
);
  logic               enable;
  logic               req_vedacao;
  logic               req_operador;
  logic [LARGURA-1:0] qtd_operador;
  logic               disp_ack;
  logic               disp_req;
  logic [LARGURA-1:0] rolhas;
  logic               min_r;
  logic               ro;
  logic               gnt_vedacao;
  logic               gnt_operador;
  logic               erro_capacidade;
  logic               alarme;
  logic [1:0]         estado;

  modport slave (
    input  enable, req_vedacao, req_operador, qtd_operador, disp_ack,
    output disp_req, rolhas, min_r, ro, gnt_vedacao, gnt_operador,
           erro_capacidade, alarme, estado
  );

  modport master (
    output enable, req_vedacao, req_operador, qtd_operador, disp_ack,
    input  disp_req, rolhas, min_r, ro, gnt_vedacao, gnt_operador,
           erro_capacidade, alarme, estado
  );
endinterface

// File: rtl/modulo_controlador_reservatorio_rolhas.sv
// Cork reservoir counter: arbitrates dispenser refill, sealing consumption and
// operator loads (one update per cycle) and runs the dispenser handshake with timeout.
`timescale 1ns/1ps
module modulo_controlador_reservatorio_rolhas #(
  parameter int LARGURA    = 7,
  parameter int CAPACIDADE = 99,
  parameter int MINIMO     = 5,
  parameter int LOTE       = 15,
  parameter int TIMEOUT    = 8
) (
  input  logic clk,
  input  logic Nclr,
  modulo_controlador_reservatorio_rolhas_if.slave bus
);

  localparam int SW = LARGURA + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef logic [SW-1:0] soma_t;
  typedef enum logic [1:0] {
    DESLIGADO = 2'b00,
    OPERANDO  = 2'b01,
    REPONDO   = 2'b10,
    FALHA     = 2'b11
  } estado_t;

  localparam soma_t CAP_S = soma_t'(CAPACIDADE);

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] rolhas_q, rolhas_d;
  logic [LARGURA-1:0] qtd_q, qtd_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               pend_v_q, pend_v_d;
  logic               pend_o_q, pend_o_d;
  logic               gnt_v_q, gnt_v_d;
  logic               gnt_o_q, gnt_o_d;
  logic               erro_q, erro_d;
  logic               ativo;
  soma_t              soma_oper;
  soma_t              soma_lote;

  // Refill result clipped to the reservoir capacity.
  function automatic logic [LARGURA-1:0] satura(input soma_t v);
    return (v > CAP_S) ? LARGURA'(CAPACIDADE) : v[LARGURA-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!Nclr) begin
      state_q  <= DESLIGADO;
      rolhas_q <= '0;
      timer_q  <= '0;
      pend_v_q <= 1'b0;
      pend_o_q <= 1'b0;
      gnt_v_q  <= 1'b0;
      gnt_o_q  <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rolhas_q <= rolhas_d;
      timer_q  <= timer_d;
      pend_v_q <= pend_v_d;
      pend_o_q <= pend_o_d;
      gnt_v_q  <= gnt_v_d;
      gnt_o_q  <= gnt_o_d;
      erro_q   <= erro_d;
    end
  end

  always_ff @(posedge clk) begin
    qtd_q <= qtd_d;
  end

  always_comb begin
    state_d   = state_q;
    rolhas_d  = rolhas_q;
    qtd_d     = qtd_q;
    timer_d   = timer_q;
    pend_v_d  = pend_v_q;
    pend_o_d  = pend_o_q;
    gnt_v_d   = 1'b0;
    gnt_o_d   = 1'b0;
    erro_d    = 1'b0;
    ativo     = bus.enable && (state_q != DESLIGADO);
    soma_oper = {1'b0, rolhas_q} + {1'b0, qtd_q};
    soma_lote = {1'b0, rolhas_q} + soma_t'(LOTE);

    // Single update slot: dispenser ack beats consumption beats operator load.
    if (ativo && (state_q == REPONDO) && bus.disp_ack) begin
      rolhas_d = satura(soma_lote);
    end else if (ativo && pend_v_q && (rolhas_q != '0)) begin
      rolhas_d = rolhas_q - LARGURA'(1);
      gnt_v_d  = 1'b1;
      pend_v_d = 1'b0;
    end else if (ativo && pend_o_q) begin
      if (soma_oper <= CAP_S) begin
        rolhas_d = soma_oper[LARGURA-1:0];
        gnt_o_d  = 1'b1;
      end else begin
        erro_d   = 1'b1;
      end
      pend_o_d = 1'b0;
    end

    if (bus.req_vedacao) pend_v_d = 1'b1;
    if (bus.req_operador) begin
      pend_o_d = 1'b1;
      qtd_d    = bus.qtd_operador;
    end

    case (state_q)
      DESLIGADO: state_d = OPERANDO;
      OPERANDO: begin
        if (rolhas_q < LARGURA'(MINIMO)) begin
          state_d = REPONDO;
          timer_d = '0;
        end
      end
      REPONDO: begin
        if (bus.disp_ack) begin
          state_d = OPERANDO;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = FALHA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = FALHA;
    endcase

    // Line stop overrides everything and drops outstanding requests.
    if (!bus.enable) begin
      state_d  = DESLIGADO;
      timer_d  = '0;
      pend_v_d = 1'b0;
      pend_o_d = 1'b0;
    end
  end

  assign bus.rolhas          = rolhas_q;
  assign bus.estado          = state_q;
  assign bus.disp_req        = (state_q == REPONDO);
  assign bus.alarme          = (state_q == FALHA);
  assign bus.min_r           = (rolhas_q < LARGURA'(MINIMO));
  assign bus.ro              = (rolhas_q == '0);
  assign bus.gnt_vedacao     = gnt_v_q;
  assign bus.gnt_operador    = gnt_o_q;
  assign bus.erro_capacidade = erro_q;

endmodule

// File: doc/modulo_controlador_reservatorio_rolhas.md
Name: modulo_controlador_reservatorio_rolhas

Overview:
- Sequences the cork (rolha) reservoir register of the filling/sealing line.
- Arbitrates three requesters that modify the cork count, one update per clock:
  - sealing station consumption (1 cork per seal)
  - operator manual load (N corks)
  - automatic dispenser refill (fixed batch)
- Runs the dispenser handshake with a timeout alarm.
- Exports the count, minimum-level and absence flags to the filling/sealing FSM and the display encoders.

Parameters:
- LARGURA, 7: width of the cork count and operator quantity.
- CAPACIDADE, 99: maximum corks held; the count never exceeds it.
- MINIMO, 5: a refill is requested when the count is below this value.
- LOTE, 15: corks delivered per dispenser acknowledge.
- TIMEOUT, 8: clock cycles allowed between a disp_req rise and disp_ack.

Ports:
- clk, in, 1: system clock (divided clock domain); all logic on the rising edge.
- Nclr, in, 1: synchronous reset, active-low.
- enable, in, 1: line start/stop level; 0 = line stopped.
- req_vedacao, in, 1: one-cycle pulse, sealing consumed one cork.
- req_operador, in, 1: one-cycle pulse (already debounced), operator loads qtd_operador corks.
- qtd_operador, in, LARGURA: quantity to load; sampled in the same cycle as req_operador.
- disp_ack, in, 1: dispenser delivered one batch; level, sampled only in REPONDO.
- disp_req, out, 1: refill request to the dispenser.
- rolhas, out, LARGURA: current cork count, registered.
- min_r, out, 1: 1 when rolhas < MINIMO.
- ro, out, 1: 1 when rolhas == 0 (cork absence).
- gnt_vedacao, out, 1: one-cycle pulse, a consumption was applied.
- gnt_operador, out, 1: one-cycle pulse, an operator load was applied.
- erro_capacidade, out, 1: one-cycle pulse, an operator load was rejected.
- alarme, out, 1: dispenser timeout alarm, level.
- estado, out, 2: FSM state code.

Behaviour:
- Reset (Nclr=0 at a clk edge): rolhas=0, state DESLIGADO, pending bits=0, timer=0. disp_req, gnt_*, erro_capacidade and alarme are 0. min_r=1, ro=1 (combinational from rolhas).
- Pending bits:
  - pend_v and pend_o are set by a req_* pulse. The operator quantity is captured into a register with pend_o.
  - A pending bit clears when its grant is issued. A new req_* in the same cycle as its grant leaves the bit set, so no request is lost.
  - A req_operador while pend_o=1 overwrites the captured quantity.
- FSM states:
  - DESLIGADO=00: no grants. Pending bits are held at 0. rolhas is held. Leaves to OPERANDO when enable=1.
  - OPERANDO=01: serves pend_v and pend_o. Goes to REPONDO when rolhas < MINIMO, with disp_req=1 from the next cycle and timer cleared.
  - REPONDO=10: disp_req=1 and the timer increments every cycle. Consumption and operator loads are still served.
    - disp_ack=1: apply the refill, disp_req=0 and go to OPERANDO in the next cycle.
    - Timer reaches TIMEOUT without disp_ack: go to FALHA.
  - FALHA=11: alarme=1, disp_req=0, consumption and operator loads still served. Exits only via Nclr=0 or enable=0 (to DESLIGADO, alarme cleared).
  - enable=0 in any state goes to DESLIGADO at the next edge, aborting any refill.
- Arbitration: at most one count update per cycle. Priority is dispenser ack > pend_v > pend_o. A losing request stays pending.
- Consumption (pend_v granted):
  - rolhas-1, gnt_vedacao pulse.
  - If rolhas==0, no grant is issued and pend_v stays pending until the count is above 0.
- Operator load (pend_o granted):
  - If rolhas+qtd <= CAPACIDADE: rolhas+qtd, gnt_operador pulse.
  - Otherwise: rolhas unchanged, erro_capacidade pulse, pend_o cleared.
  - qtd=0 is granted with no change.
- Refill: rolhas = min(rolhas+LOTE, CAPACIDADE), saturating.
- Arithmetic is done in LARGURA+1 bits to detect overflow. No wrap-around is permitted.
- Latency: a request pulse at edge n produces its grant and the updated rolhas at edge n+1, when it is uncontested.
- min_r and ro follow the registered rolhas combinationally.

Test Plan:
- Reset, enable=1, no ack:
  - rolhas=0, ro=1, min_r=1.
  - Next cycle estado=01, then 10 with disp_req=1.
  - After 8 cycles estado=11, alarme=1, disp_req=0.
- From rolhas=0 in REPONDO, pulse disp_ack:
  - rolhas=15, disp_req=0, estado=01.
  - 11 req_vedacao pulses leave rolhas=4, which triggers a new disp_req.
- rolhas=90, req_operador qtd=9 -> rolhas=99, gnt_operador. A second load of qtd=1 -> erro_capacidade pulse, rolhas=99.
- rolhas=3 in REPONDO, disp_ack and req_vedacao in the same cycle:
  - Refill first: rolhas=18.
  - Consumption next cycle: rolhas=17, gnt_vedacao.
- rolhas=0 with disp_ack held 0, req_vedacao pulse:
  - No gnt_vedacao, request stays pending.
  - After disp_ack, the cycles run rolhas=15 then 14, with gnt_vedacao.
- enable=0 mid-REPONDO, also issued from FALHA:
  - Next edge estado=00, disp_req=0, alarme=0, rolhas held.
  - Re-enabling restarts the refill sequence.
